// File: rtl/cf_pkg.sv
// Shared control-flow types and default widths for the control unit, datapath and PC unit.
package cf_pkg;

    localparam int unsigned CF_PC_W   = 16;
    localparam int unsigned CF_DATA_W = 16;
    localparam int unsigned CNT_W     = 3;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_GE   = 2'b01,
        BR_LE   = 2'b10,
        BR_EQ   = 2'b11
    } br_code_e;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } cf_state_e;

    typedef struct packed {
        logic z;
        logic n;
    } cf_flags_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch resolution from the registered compare flags; jump always wins.
module branch_cond_eval
    import cf_pkg::*;
(
    input  br_code_e branch,
    input  logic     jump,
    input  logic     flag_z,
    input  logic     flag_n,
    output logic     take
);

    always_comb begin
        take = 1'b0;
        case (branch)
            BR_GE:   take = !flag_n;
            BR_LE:   take = flag_n | flag_z;
            BR_EQ:   take = flag_z;
            default: take = 1'b0;
        endcase
        if (jump) begin
            take = 1'b1;
        end
    end

endmodule

// File: rtl/branch_pc_unit.sv
// Program counter owner: resolves jumps/branches against the compare flags and
// holds flush high for a fixed number of enabled cycles after every redirect.
module branch_pc_unit
    import cf_pkg::*;
#(
    parameter int unsigned PC_W         = CF_PC_W,
    parameter int unsigned DATA_W       = CF_DATA_W,
    parameter int unsigned RESET_PC     = 0,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              instr_valid,
    input  logic              jump,
    input  logic [1:0]        branch,
    input  logic              cmp_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [PC_W-1:0]   offset,
    output logic [PC_W-1:0]   pc,
    output logic              flush,
    output logic              taken,
    output logic              flag_z,
    output logic              flag_n
);

    cf_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             flush_q, flush_d;
    logic             taken_q, taken_d;
    cf_flags_t        flags_q, flags_d;
    logic             take_c;
    logic             accept_c;
    logic             redirect_c;

    branch_cond_eval u_cond (
        .branch (br_code_e'(branch)),
        .jump   (jump),
        .flag_z (flags_q.z),
        .flag_n (flags_q.n),
        .take   (take_c)
    );

    // Control inputs are only honoured on the right path of an advancing pipeline.
    assign accept_c   = en && instr_valid && (state_q == RUN);
    assign redirect_c = accept_c && take_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            pc_q    <= PC_W'(RESET_PC);
            flush_q <= 1'b0;
            taken_q <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            taken_q <= taken_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (en) begin
            case (state_q)
                RUN: begin
                    if (redirect_c) begin
                        state_d = FLUSH;
                        cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                    end
                end
                FLUSH: begin
                    if (cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        pc_d    = pc_q;
        flush_d = flush_q;
        taken_d = 1'b0;
        flags_d = flags_q;
        if (en) begin
            pc_d = pc_q + PC_W'(1);
            case (state_q)
                RUN: begin
                    flush_d = 1'b0;
                    if (redirect_c) begin
                        pc_d    = pc_q + offset;
                        taken_d = 1'b1;
                        flush_d = 1'b1;
                    end
                end
                FLUSH:   flush_d = (cnt_q != '0);
                default: flush_d = 1'b0;
            endcase
            // New flags land after this edge, so a same-cycle branch sees the old ones.
            if (accept_c && cmp_valid) begin
                flags_d.z = (alu_result == '0);
                flags_d.n = alu_result[DATA_W-1];
            end
        end
    end

    assign pc     = pc_q;
    assign flush  = flush_q;
    assign taken  = taken_q;
    assign flag_z = flags_q.z;
    assign flag_n = flags_q.n;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed self-checking bench for branch_pc_unit with hand-computed PC/flag expectations.
module tb_branch_pc_unit;
    import cf_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        instr_valid;
    logic        jump;
    logic [1:0]  branch;
    logic        cmp_valid;
    logic [15:0] alu_result;
    logic [15:0] offset;
    logic [15:0] pc;
    logic        flush;
    logic        taken;
    logic        flag_z;
    logic        flag_n;

    int checks   = 0;
    int failures = 0;

    branch_pc_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .instr_valid (instr_valid),
        .jump        (jump),
        .branch      (branch),
        .cmp_valid   (cmp_valid),
        .alu_result  (alu_result),
        .offset      (offset),
        .pc          (pc),
        .flush       (flush),
        .taken       (taken),
        .flag_z      (flag_z),
        .flag_n      (flag_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && en && instr_valid && dut.state_q == RUN) begin
            assert (!$isunknown({jump, branch}))
                else $error("unknown jump/branch on a valid instruction in RUN");
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        instr_valid = 1'b0;
        jump        = 1'b0;
        branch      = 2'b00;
        cmp_valid   = 1'b0;
        alu_result  = '0;
        offset      = '0;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] e_pc, input logic e_fl,
                              input logic e_tk);
        check({tag, ".pc"}, 32'(pc), 32'(e_pc));
        check({tag, ".flush"}, 32'(flush), 32'(e_fl));
        check({tag, ".taken"}, 32'(taken), 32'(e_tk));
    endtask

    task automatic expect_flags(input string tag, input logic e_z, input logic e_n);
        check({tag, ".flag_z"}, 32'(flag_z), 32'(e_z));
        check({tag, ".flag_n"}, 32'(flag_n), 32'(e_n));
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        idle();
        #2;
        expect_out("reset", 16'h0000, 1'b0, 1'b0);
        expect_flags("reset", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Jump to FFFC so the flush completes with pc at FFFE.
        instr_valid = 1'b1; jump = 1'b1; offset = 16'hFFFC;
        step();
        expect_out("jmp_fffc", 16'hFFFC, 1'b1, 1'b1);
        idle();
        step();
        expect_out("jmp_fl1", 16'hFFFD, 1'b1, 1'b0);
        step();
        expect_out("jmp_fl2", 16'hFFFE, 1'b0, 1'b0);
        step();
        expect_out("wrap0", 16'hFFFF, 1'b0, 1'b0);
        step();
        expect_out("wrap1", 16'h0000, 1'b0, 1'b0);
        step();
        expect_out("wrap2", 16'h0001, 1'b0, 1'b0);

        // CMB with zero result, then SPE +8 at pc=10.
        instr_valid = 1'b1; cmp_valid = 1'b1; alu_result = 16'h0000;
        step();
        expect_out("cmb0", 16'h0002, 1'b0, 1'b0);
        expect_flags("cmb0", 1'b1, 1'b0);
        idle();
        for (int i = 0; i < 8; i++) step();
        check("pc_at_10", 32'(pc), 32'd10);
        instr_valid = 1'b1; branch = 2'b11; offset = 16'd8;
        step();
        expect_out("spe_taken", 16'd18, 1'b1, 1'b1);
        idle();
        step();
        expect_out("spe_fl1", 16'd19, 1'b1, 1'b0);
        step();
        expect_out("spe_fl2", 16'd20, 1'b0, 1'b0);

        // Negative compare: SMAE not taken, SMEE at pc=30 taken to 26.
        instr_valid = 1'b1; cmp_valid = 1'b1; alu_result = 16'h8003;
        step();
        expect_flags("cmb_neg", 1'b0, 1'b1);
        check("cmb_neg.pc", 32'(pc), 32'd21);
        idle();
        instr_valid = 1'b1; branch = 2'b01; offset = 16'hFFFC;
        step();
        expect_out("smae_nt", 16'd22, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < 8; i++) step();
        check("pc_at_30", 32'(pc), 32'd30);
        instr_valid = 1'b1; branch = 2'b10; offset = 16'hFFFC;
        step();
        expect_out("smee_t", 16'd26, 1'b1, 1'b1);

        // Jump and CMB during FLUSH are wrong-path and ignored.
        idle();
        instr_valid = 1'b1; jump = 1'b1; offset = 16'd100;
        cmp_valid = 1'b1; alu_result = 16'h0000;
        step();
        expect_out("flush_ign", 16'd27, 1'b1, 1'b0);
        expect_flags("flush_ign", 1'b0, 1'b1);
        idle();
        step();
        expect_out("flush_end", 16'd28, 1'b0, 1'b0);

        // Same-cycle CMB and SPE: branch uses old flag_z=0.
        instr_valid = 1'b1; cmp_valid = 1'b1; alu_result = 16'h0000;
        branch = 2'b11; offset = 16'd50;
        step();
        expect_out("same_cyc", 16'd29, 1'b0, 1'b0);
        expect_flags("same_cyc", 1'b1, 1'b0);

        // en low inside FLUSH freezes pc/counter/flush and clears taken.
        idle();
        instr_valid = 1'b1; jump = 1'b1; offset = 16'd100;
        step();
        expect_out("jmp129", 16'd129, 1'b1, 1'b1);
        idle();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out($sformatf("hold%0d", i), 16'd129, 1'b1, 1'b0);
        end
        en = 1'b1;
        step();
        expect_out("resume1", 16'd130, 1'b1, 1'b0);
        step();
        expect_out("resume2", 16'd131, 1'b0, 1'b0);

        // Jump priority over a not-taken SMAE (flag_n=1).
        instr_valid = 1'b1; cmp_valid = 1'b1; alu_result = 16'h8003;
        step();
        expect_flags("cmb_neg2", 1'b0, 1'b1);
        idle();
        instr_valid = 1'b1; jump = 1'b1; branch = 2'b01; offset = 16'd10;
        step();
        expect_out("jmp_prio", 16'd142, 1'b1, 1'b1);
        idle();

        // Asynchronous reset mid-FLUSH, checked before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_rst", 16'h0000, 1'b0, 1'b0);
        expect_flags("async_rst", 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        step();
        expect_out("post_rst", 16'h0001, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
